ex_mem_stage: RTL and testbench

Execute-to-memory pipeline stage of the RISC-V RV32I core, directly downstream of the ALU. It captures the ALU result and the Z/N/C/O flags together with the control and store data travelling with the instruction. It resolves conditional branches from the flags, issues a one-cycle redirect to fetch, and presents a registered, valid/ready-handshaked bundle to the memory stage.

---
 rtl/ex_mem_stage.sv | 188 ++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
// Execute-to-memory pipeline stage of an RV32I core. Captures the ALU result,
// store data and control bits into a one-entry valid/ready register, resolves
// conditional branches from the ALU Z/N/C/O flags (flags come from A-B, with
// C=1 meaning A>=B unsigned), and emits a one-cycle registered redirect pulse
// for taken branches and jumps.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      EX-side handshake (in_ready = !out_valid || out_ready)
//   alu_result, *flag        ALU result and flags
//   rs2_data, rd_addr, funct3, is_branch, is_jump, branch_target,
//   mem_read, mem_write, reg_write, mem_to_reg   instruction bundle
//   flush                    squash held entry, block acceptance this cycle
//   out_valid / out_ready    MEM-side handshake
//   out_*                    registered bundle to MEM
//   redirect, redirect_pc    one-cycle taken pulse and its target
//   bad_branch               one-cycle pulse, branch with funct3 010/011
//   branch_count, taken_count  saturating branch statistics
//
// Configuration macro: EX_MEM_BRANCH_STATS_EN enables the statistics
// counters; when undefined both counters are tied to zero.
// ---------------------------------------------------------------------------
module ex_mem_stage #(
   parameter int XLEN   = 32,
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   alu_result,
   input  logic              zflag,
   input  logic              nflag,
   input  logic              cflag,
   input  logic              oflag,
   input  logic [XLEN-1:0]   rs2_data,
   input  logic [4:0]        rd_addr,
   input  logic [2:0]        funct3,
   input  logic              is_branch,
   input  logic              is_jump,
   input  logic [XLEN-1:0]   branch_target,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              reg_write,
   input  logic              mem_to_reg,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_result,
   output logic [XLEN-1:0]   out_store_data,
   output logic [4:0]        out_rd,
   output logic [2:0]        out_funct3,
   output logic              out_mem_read,
   output logic              out_mem_write,
   output logic              out_reg_write,
   output logic              out_mem_to_reg,
   output logic              redirect,
   output logic [XLEN-1:0]   redirect_pc,
   output logic              bad_branch,
   output logic [PERF_W-1:0] branch_count,
   output logic [PERF_W-1:0] taken_count
);

   // Branch condition from SUB flags; unsupported encodings resolve not-taken.
   function automatic logic branch_cond(input logic [2:0] f3, input logic z,
                                        input logic n, input logic c, input logic o);
      logic r;
      case (f3)
         3'b000:  r = z;
         3'b001:  r = !z;
         3'b100:  r = n ^ o;
         3'b101:  r = !(n ^ o);
         3'b110:  r = !c;
         3'b111:  r = c;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   result_q, store_data_q, redirect_pc_q;
   logic [4:0]        rd_q;
   logic [2:0]        funct3_q;
   logic              mem_read_q, mem_write_q, reg_write_q, mem_to_reg_q;
   logic              redirect_q, redirect_d, bad_branch_q, bad_branch_d;
   logic              accept_s, is_cond_s, cond_true_s, taken_s, bad_f3_s;

   assign in_ready    = !out_valid_q || out_ready;
   assign accept_s    = in_valid && in_ready && !flush;
   // A jump wins over a simultaneous branch flag.
   assign is_cond_s   = is_branch && !is_jump;
   assign cond_true_s = branch_cond(funct3, zflag, nflag, cflag, oflag);
   assign taken_s     = is_jump || (is_cond_s && cond_true_s);
   assign bad_f3_s    = is_cond_s && ((funct3 == 3'b010) || (funct3 == 3'b011));
   assign redirect_d   = accept_s && taken_s;
   assign bad_branch_d = accept_s && bad_f3_s;

   // Next value of the entry-valid flag; flush overrides accept and drain.
   always_comb begin
      out_valid_d = out_valid_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept_s) begin
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Pipeline register, redirect/bad_branch pulses and redirect target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         result_q      <= {XLEN{1'b0}};
         store_data_q  <= {XLEN{1'b0}};
         rd_q          <= 5'd0;
         funct3_q      <= 3'd0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         reg_write_q   <= 1'b0;
         mem_to_reg_q  <= 1'b0;
         redirect_q    <= 1'b0;
         bad_branch_q  <= 1'b0;
         redirect_pc_q <= {XLEN{1'b0}};
      end else begin
         out_valid_q  <= out_valid_d;
         redirect_q   <= redirect_d;
         bad_branch_q <= bad_branch_d;
         if (accept_s) begin
            result_q     <= alu_result;
            store_data_q <= rs2_data;
            rd_q         <= rd_addr;
            funct3_q     <= funct3;
            // Conditional branches must not write registers or touch memory.
            mem_read_q   <= mem_read  && !is_cond_s;
            mem_write_q  <= mem_write && !is_cond_s;
            reg_write_q  <= reg_write && !is_cond_s;
            mem_to_reg_q <= mem_to_reg;
         end
         if (redirect_d) begin
            redirect_pc_q <= branch_target;
         end
      end
   end

   assign out_valid      = out_valid_q;
   assign out_result     = result_q;
   assign out_store_data = store_data_q;
   assign out_rd         = rd_q;
   assign out_funct3     = funct3_q;
   assign out_mem_read   = mem_read_q;
   assign out_mem_write  = mem_write_q;
   assign out_reg_write  = reg_write_q;
   assign out_mem_to_reg = mem_to_reg_q;
   assign redirect       = redirect_q;
   assign redirect_pc    = redirect_pc_q;
   assign bad_branch     = bad_branch_q;

`ifdef EX_MEM_BRANCH_STATS_EN
   logic [PERF_W-1:0] branch_count_q, taken_count_q;

   // Saturating statistics; jumps excluded, only rst clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_count_q <= {PERF_W{1'b0}};
         taken_count_q  <= {PERF_W{1'b0}};
      end else if (accept_s && is_cond_s) begin
         if (branch_count_q != {PERF_W{1'b1}}) begin
            branch_count_q <= branch_count_q + {{(PERF_W-1){1'b0}}, 1'b1};
         end
         if (cond_true_s && (taken_count_q != {PERF_W{1'b1}})) begin
            taken_count_q <= taken_count_q + {{(PERF_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign branch_count = branch_count_q;
   assign taken_count  = taken_count_q;
`else
   assign branch_count = {PERF_W{1'b0}};
   assign taken_count  = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

   typedef struct packed {
      logic        in_valid, flush, out_ready, is_branch, is_jump;
      logic        mr, mw, rw, m2r;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] a, b, res, sd, tgt;
   } stim_t;

   typedef struct packed {
      logic [31:0] res, sd;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        mr, mw, rw, m2r;
   } bun_t;

   logic clk, rst;
   logic in_valid, in_ready, zflag, nflag, cflag, oflag;
   logic [31:0] alu_result, rs2_data, branch_target;
   logic [4:0]  rd_addr;
   logic [2:0]  funct3;
   logic is_branch, is_jump, mem_read, mem_write, reg_write, mem_to_reg, flush;
   logic out_valid, out_ready;
   logic [31:0] out_result, out_store_data, redirect_pc, branch_count, taken_count;
   logic [4:0]  out_rd;
   logic [2:0]  out_funct3;
   logic out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg, redirect, bad_branch;

   ex_mem_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_result(alu_result), .zflag(zflag), .nflag(nflag), .cflag(cflag), .oflag(oflag),
      .rs2_data(rs2_data), .rd_addr(rd_addr), .funct3(funct3),
      .is_branch(is_branch), .is_jump(is_jump), .branch_target(branch_target),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
      .out_funct3(out_funct3), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
      .redirect(redirect), .redirect_pc(redirect_pc), .bad_branch(bad_branch),
      .branch_count(branch_count), .taken_count(taken_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;
   bun_t sb_q[$];
   logic mon_en = 1'b0;

   // reference model state: cur_* describe outputs after the latest edge
   logic        cur_valid, cur_redir, cur_bad, exp_in_ready;
   logic        nxt_valid, nxt_redir, nxt_bad;
   logic [31:0] cur_pc, nxt_pc, cur_bc, nxt_bc, cur_tc, nxt_tc;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Branch outcome from operand comparison (flags are produced from A-B).
   function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic stim_t idle_s(input logic ordy);
      stim_t s = '0;
      s.out_ready = ordy;
      return s;
   endfunction

   function automatic stim_t alu_s(input logic [31:0] res, input logic [4:0] rd);
      stim_t s = idle_s(1'b1);
      s.in_valid = 1'b1; s.rw = 1'b1; s.res = res; s.rd = rd; s.sd = 32'hDEAD_0000 | {27'd0, rd};
      return s;
   endfunction

   function automatic stim_t br_s(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] tgt);
      stim_t s = idle_s(1'b1);
      s.in_valid = 1'b1; s.is_branch = 1'b1; s.f3 = f3; s.a = a; s.b = b; s.tgt = tgt;
      s.rw = 1'b1; s.mw = 1'b1; s.mr = 1'b1; s.rd = 5'd9; s.res = a - b;
      return s;
   endfunction

   function automatic stim_t jal_s(input logic [31:0] tgt, input logic [4:0] rd);
      stim_t s = idle_s(1'b1);
      s.in_valid = 1'b1; s.is_jump = 1'b1; s.rw = 1'b1; s.rd = rd; s.tgt = tgt; s.res = tgt + 32'd4;
      return s;
   endfunction

   // one clock: apply stimulus after the edge, predict effects of the next edge
   task automatic step(input stim_t s);
      logic acc, tk, cond;
      logic [32:0] diff;
      bun_t bn;
      @(posedge clk);
      cur_valid = nxt_valid; cur_redir = nxt_redir; cur_bad = nxt_bad;
      cur_pc = nxt_pc; cur_bc = nxt_bc; cur_tc = nxt_tc;
      #1;
      diff = {1'b0, s.a} - {1'b0, s.b};
      in_valid = s.in_valid; flush = s.flush; out_ready = s.out_ready;
      is_branch = s.is_branch; is_jump = s.is_jump; funct3 = s.f3; rd_addr = s.rd;
      mem_read = s.mr; mem_write = s.mw; reg_write = s.rw; mem_to_reg = s.m2r;
      alu_result = s.res; rs2_data = s.sd; branch_target = s.tgt;
      zflag = (s.a == s.b); nflag = diff[31]; cflag = !diff[32];
      oflag = (s.a[31] != s.b[31]) && (diff[31] != s.a[31]);

      exp_in_ready = !cur_valid || s.out_ready;
      acc  = s.in_valid && exp_in_ready && !s.flush;
      cond = s.is_branch && !s.is_jump;
      tk   = s.is_jump || (cond && ref_taken(s.f3, s.a, s.b));
      nxt_valid = s.flush ? 1'b0 : (acc ? 1'b1 : (s.out_ready ? 1'b0 : cur_valid));
      nxt_redir = acc && tk;
      if (acc && tk) nxt_pc = s.tgt;
      nxt_bad = acc && cond && (s.f3 == 3'd2 || s.f3 == 3'd3);
      if (acc) begin
         bn.res = s.res; bn.sd = s.sd; bn.rd = s.rd; bn.f3 = s.f3;
         bn.mr = cond ? 1'b0 : s.mr; bn.mw = cond ? 1'b0 : s.mw;
         bn.rw = cond ? 1'b0 : s.rw; bn.m2r = s.m2r;
         sb_q.push_back(bn);
      end
`ifdef EX_MEM_BRANCH_STATS_EN
      if (acc && cond) begin
         if (nxt_bc != 32'hFFFF_FFFF) nxt_bc = nxt_bc + 32'd1;
         if (ref_taken(s.f3, s.a, s.b) && nxt_tc != 32'hFFFF_FFFF) nxt_tc = nxt_tc + 32'd1;
      end
`endif
   endtask

   task automatic do_reset();
      stim_t s = idle_s(1'b0);
      mon_en = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; is_branch = s.is_branch; is_jump = 1'b0;
      sb_q.delete();
      cur_valid = 1'b0; cur_redir = 1'b0; cur_bad = 1'b0; nxt_valid = 1'b0; nxt_redir = 1'b0; nxt_bad = 1'b0;
      cur_pc = 32'd0; nxt_pc = 32'd0; cur_bc = 32'd0; nxt_bc = 32'd0; cur_tc = 32'd0; nxt_tc = 32'd0;
      exp_in_ready = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("reset_outputs", {4'd0, out_valid, out_result, out_store_data, out_rd, out_funct3,
                            out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg},
          80'd0);
      chk("reset_pulses_pc", {46'd0, redirect, bad_branch, redirect_pc}, 80'd0);
      chk("reset_counters", {16'd0, branch_count, taken_count}, 80'd0);
      mon_en = 1'b1;
   endtask

   // monitor: per-cycle pulse/flag checks and scoreboard pops on MEM handshake
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         chk("in_ready", {79'd0, in_ready}, {79'd0, exp_in_ready});
         chk("out_valid", {79'd0, out_valid}, {79'd0, cur_valid});
         chk("redirect", {79'd0, redirect}, {79'd0, cur_redir});
         chk("redirect_pc", {48'd0, redirect_pc}, {48'd0, cur_pc});
         chk("bad_branch", {79'd0, bad_branch}, {79'd0, cur_bad});
         chk("counters", {16'd0, branch_count, taken_count}, {16'd0, cur_bc, cur_tc});
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               total_cnt++;
               $display("FAIL bundle: got unexpected out_valid, expected empty scoreboard at %0t", $time);
            end else begin
               chk("bundle", {4'd0, out_result, out_store_data, out_rd, out_funct3,
                              out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg},
                   {4'd0, sb_q[0]});
               if (out_ready) void'(sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      stim_t s;
      rst = 1'b1;
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; is_branch = 1'b0; is_jump = 1'b0;
      funct3 = 3'd0; rd_addr = 5'd0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
      mem_to_reg = 1'b0; alu_result = 32'd0; rs2_data = 32'd0; branch_target = 32'd0;
      zflag = 1'b0; nflag = 1'b0; cflag = 1'b0; oflag = 1'b0;
      do_reset();
      step(idle_s(1'b1)); step(idle_s(1'b1));

      // ADD result, then branches of each kind
      step(alu_s(32'h0000_0010, 5'd5));
      step(idle_s(1'b1));
      step(br_s(3'd0, 32'd7, 32'd7, 32'h0000_0100));          // BEQ taken
      step(br_s(3'd0, 32'd7, 32'd8, 32'h0000_0200));          // BEQ not taken
      step(br_s(3'd4, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h300)); // BLT N=1,O=1
      step(br_s(3'd6, 32'd1, 32'd2, 32'h0000_0400));          // BLTU C=0
      step(br_s(3'd7, 32'd5, 32'd3, 32'h0000_0500));          // BGEU C=1
      step(br_s(3'd2, 32'd5, 32'd5, 32'h0000_0600));          // bad funct3
      step(idle_s(1'b1));

      // backpressure for 3 cycles, then drain and accept on one edge
      s = alu_s(32'h0000_AAAA, 5'd3); s.out_ready = 1'b0; step(s);
      s = alu_s(32'h0000_BBBB, 5'd4); s.out_ready = 1'b0;
      step(s); step(s); step(s);
      s.out_ready = 1'b1; step(s);
      step(idle_s(1'b1));

      // flush with a JAL on the input while an entry is held
      step(alu_s(32'h0000_CCCC, 5'd6));
      s = jal_s(32'h0000_0700, 5'd1); s.flush = 1'b1; step(s);
      step(idle_s(1'b1)); step(idle_s(1'b1));

      // statistics: 3 BEQ (2 taken) then a JAL
      do_reset();
      step(br_s(3'd0, 32'd9, 32'd9, 32'h0000_0800));
      step(br_s(3'd0, 32'd9, 32'd1, 32'h0000_0900));
      step(br_s(3'd0, 32'd2, 32'd2, 32'h0000_0A00));
      step(jal_s(32'h0000_0B00, 5'd1));
      step(idle_s(1'b1)); step(idle_s(1'b1));
`ifdef EX_MEM_BRANCH_STATS_EN
      chk("stats_after_seq", {16'd0, branch_count, taken_count}, {16'd0, 32'd3, 32'd2});
`else
      chk("stats_after_seq", {16'd0, branch_count, taken_count}, 80'd0);
`endif

      // randomized traffic with a reset in the middle
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         s = idle_s($urandom_range(0, 9) < 7);
         s.in_valid  = ($urandom_range(0, 9) < 7);
         s.flush     = s.out_ready && ($urandom_range(0, 19) == 0);
         s.is_jump   = ($urandom_range(0, 6) == 0);
         s.is_branch = ($urandom_range(0, 9) < 4);
         s.f3  = 3'($urandom_range(0, 7));
         s.rd  = 5'($urandom_range(0, 31));
         s.mr  = 1'($urandom_range(0, 1)); s.mw = 1'($urandom_range(0, 1));
         s.rw  = 1'($urandom_range(0, 1)); s.m2r = 1'($urandom_range(0, 1));
         s.a   = $urandom();
         s.b   = ($urandom_range(0, 3) == 0) ? s.a : $urandom();
         s.res = $urandom(); s.sd = $urandom(); s.tgt = $urandom();
         step(s);
      end

      step(idle_s(1'b1)); step(idle_s(1'b1)); step(idle_s(1'b1));
      chk("scoreboard_drained", 80'(sb_q.size()), 80'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
